// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus bundle: synchronous instruction-memory port plus the
// valid/ready hand-off to decode. master = fetch stage, slave = memory/decode side.
interface instruction_fetch_if;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] pc_plus4;
  logic        valid_out;
  logic        ready_in;

  modport master (
    output imem_en, imem_addr, instruction, pc_plus4, valid_out,
    input  imem_rdata, ready_in
  );

  modport slave (
    input  imem_en, imem_addr, instruction, pc_plus4, valid_out,
    output imem_rdata, ready_in
  );
endinterface

// File: rtl/instruction_fetch.sv
// MIPS32 instruction fetch: PC, 1-cycle-latency imem requests, out register with
// one-entry skid, branch/jump redirect. IFETCH_PERF_EN adds stall/redirect counters.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset,
  instruction_fetch_if.master bus,
  input  logic                branch_taken,
  input  logic [15:0]         branch_imm,
  input  logic                jump,
  input  logic [25:0]         jump_addr,
  input  logic [31:0]         redirect_pc4
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]         stall_cycles,
  output logic [31:0]         redirect_count
`endif
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HELD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        inflight_q, inflight_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] skid_word_q, skid_word_d;
  logic [31:0] skid_pc4_q, skid_pc4_d;
  logic        skid_full_q, skid_full_d;

  logic        redirect_s;
  logic        req_s;
  logic        accept_s;
  logic        out_free_s;
  logic        stall_s;
  logic [31:0] target_s;

  // Redirect target and request/accept qualifiers
  always_comb begin
    redirect_s = branch_taken || jump;
    if (jump) begin
      target_s = {redirect_pc4[31:28], jump_addr, 2'b00};
    end else begin
      target_s = redirect_pc4 + {{14{branch_imm[15]}}, branch_imm, 2'b00};
    end
    req_s      = !reset && !skid_full_q && !(valid_q && !bus.ready_in && inflight_q);
    accept_s   = valid_q && bus.ready_in;
    out_free_s = !valid_q || accept_s;
    stall_s    = valid_q && !bus.ready_in;
  end

  // PC, out register and skid next-state; pc_q is always the returning word's PC+4
  always_comb begin
    pc_d        = pc_q;
    inflight_d  = inflight_q;
    instr_d     = instr_q;
    pc4_d       = pc4_q;
    valid_d     = valid_q;
    skid_word_d = skid_word_q;
    skid_pc4_d  = skid_pc4_q;
    skid_full_d = skid_full_q;
    if (redirect_s) begin
      pc_d        = target_s;
      valid_d     = 1'b0;
      skid_full_d = 1'b0;
      inflight_d  = 1'b0;
    end else begin
      if (req_s) begin
        pc_d = pc_q + 32'd4;
      end else begin
        pc_d = pc_q;
      end
      inflight_d = req_s;
      if (out_free_s) begin
        if (skid_full_q) begin
          instr_d     = skid_word_q;
          pc4_d       = skid_pc4_q;
          valid_d     = 1'b1;
          skid_full_d = inflight_q;
          if (inflight_q) begin
            skid_word_d = bus.imem_rdata;
            skid_pc4_d  = pc_q;
          end else begin
            skid_word_d = skid_word_q;
            skid_pc4_d  = skid_pc4_q;
          end
        end else if (inflight_q) begin
          instr_d = bus.imem_rdata;
          pc4_d   = pc_q;
          valid_d = 1'b1;
        end else begin
          valid_d = 1'b0;
        end
      end else if (inflight_q) begin
        skid_word_d = bus.imem_rdata;
        skid_pc4_d  = pc_q;
        skid_full_d = 1'b1;
      end else begin
        skid_full_d = skid_full_q;
      end
    end
  end

  // Fetch sequencing state
  always_comb begin
    state_d = state_q;
    if (redirect_s) begin
      state_d = RUN;
    end else begin
      case (state_q)
        BOOT: begin
          if (req_s) state_d = RUN;
          else       state_d = BOOT;
        end
        RUN: begin
          if (stall_s) state_d = HELD;
          else         state_d = RUN;
        end
        HELD: begin
          if (bus.ready_in) state_d = RUN;
          else              state_d = HELD;
        end
        default: state_d = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= BOOT;
      pc_q        <= RESET_PC;
      inflight_q  <= 1'b0;
      instr_q     <= 32'h0000_0000;
      pc4_q       <= 32'h0000_0000;
      valid_q     <= 1'b0;
      skid_word_q <= 32'h0000_0000;
      skid_pc4_q  <= 32'h0000_0000;
      skid_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inflight_q  <= inflight_d;
      instr_q     <= instr_d;
      pc4_q       <= pc4_d;
      valid_q     <= valid_d;
      skid_word_q <= skid_word_d;
      skid_pc4_q  <= skid_pc4_d;
      skid_full_q <= skid_full_d;
    end
  end

  assign bus.imem_en     = req_s;
  assign bus.imem_addr   = pc_q;
  assign bus.instruction = instr_q;
  assign bus.pc_plus4    = pc4_q;
  assign bus.valid_out   = valid_q;

`ifdef IFETCH_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] redir_cnt_q, redir_cnt_d;

  // Saturating performance counters
  always_comb begin
    if (stall_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (redirect_s && (redir_cnt_q != 32'hFFFF_FFFF)) begin
      redir_cnt_d = redir_cnt_q + 32'd1;
    end else begin
      redir_cnt_d = redir_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'h0000_0000;
      redir_cnt_q <= 32'h0000_0000;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end

  assign stall_cycles   = stall_cnt_q;
  assign redirect_count = redir_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: memory word at address a is a>>2.
// dut0 uses RESET_PC=0, dut1 uses RESET_PC=FFFF_FFF8 to exercise PC wrap.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        branch_taken;
  logic [15:0] branch_imm;
  logic        jump;
  logic [25:0] jump_addr;
  logic [31:0] redirect_pc4;

  int n_assert = 0;
  int n_fail   = 0;

  instruction_fetch_if if0();
  instruction_fetch_if if1();

`ifdef IFETCH_PERF_EN
  logic [31:0] sc0, rc0, sc1, rc1;
`endif

  always #5 clk = ~clk;

  instruction_fetch #(.RESET_PC(32'h0000_0000)) dut0 (
    .clk          (clk),
    .reset        (reset),
    .bus          (if0),
    .branch_taken (branch_taken),
    .branch_imm   (branch_imm),
    .jump         (jump),
    .jump_addr    (jump_addr),
    .redirect_pc4 (redirect_pc4)
`ifdef IFETCH_PERF_EN
    ,
    .stall_cycles   (sc0),
    .redirect_count (rc0)
`endif
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut1 (
    .clk          (clk),
    .reset        (reset),
    .bus          (if1),
    .branch_taken (1'b0),
    .branch_imm   (16'h0000),
    .jump         (1'b0),
    .jump_addr    (26'h000_0000),
    .redirect_pc4 (32'h0000_0000)
`ifdef IFETCH_PERF_EN
    ,
    .stall_cycles   (sc1),
    .redirect_count (rc1)
`endif
  );

  always @(posedge clk) begin
    if (if0.imem_en) if0.imem_rdata <= {2'b00, if0.imem_addr[31:2]};
    if (if1.imem_en) if1.imem_rdata <= {2'b00, if1.imem_addr[31:2]};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset        = 1'b1;
    branch_taken = 1'b0;
    branch_imm   = 16'h0000;
    jump         = 1'b0;
    jump_addr    = 26'h000_0000;
    redirect_pc4 = 32'h0000_0000;
    if0.ready_in = 1'b1;
    if1.ready_in = 1'b1;

    repeat (3) tick();
    #1;
    check("rst_valid", {31'd0, if0.valid_out}, 32'd0);
    check("rst_instr", if0.instruction, 32'd0);
    check("rst_pc4",   if0.pc_plus4, 32'd0);
    check("rst_en",    {31'd0, if0.imem_en}, 32'd0);
    check("rst_addr",  if0.imem_addr, 32'd0);
    check("rst_addr1", if1.imem_addr, 32'hFFFF_FFF8);

    reset = 1'b0;
    #1;
    check("first_en",    {31'd0, if0.imem_en}, 32'd1);
    check("first_addr",  if0.imem_addr, 32'd0);
    check("first_addr1", if1.imem_addr, 32'hFFFF_FFF8);

    tick(); #1;
    check("c1_valid", {31'd0, if0.valid_out}, 32'd0);
    check("c1_addr",  if0.imem_addr, 32'd4);
    check("c1_addr1", if1.imem_addr, 32'hFFFF_FFFC);

    tick(); #1;
    check("c2_valid",  {31'd0, if0.valid_out}, 32'd1);
    check("c2_instr",  if0.instruction, 32'd0);
    check("c2_pc4",    if0.pc_plus4, 32'd4);
    check("w_instr0",  if1.instruction, 32'h3FFF_FFFE);
    check("w_pc4_0",   if1.pc_plus4, 32'hFFFF_FFFC);
    check("w_addr2",   if1.imem_addr, 32'h0000_0000);

    tick(); #1;
    check("s_instr1", if0.instruction, 32'd1);
    check("s_pc4_1",  if0.pc_plus4, 32'd8);
    check("w_instr1", if1.instruction, 32'h3FFF_FFFF);
    check("w_pc4_1",  if1.pc_plus4, 32'h0000_0000);

    tick(); #1;
    check("s_instr2", if0.instruction, 32'd2);
    check("s_pc4_2",  if0.pc_plus4, 32'd12);
    check("w_instr2", if1.instruction, 32'h0000_0000);
    check("w_pc4_2",  if1.pc_plus4, 32'h0000_0004);

    // stall: ready_in low for 5 cycles
    tick();
    if0.ready_in = 1'b0;
    #1;
    check("st_instr", if0.instruction, 32'd3);
    check("st_pc4",   if0.pc_plus4, 32'd16);
    check("st_en",    {31'd0, if0.imem_en}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      check("st_hold_instr", if0.instruction, 32'd3);
      check("st_hold_en",    {31'd0, if0.imem_en}, 32'd0);
    end
    tick();
    if0.ready_in = 1'b1;
    #1;
    check("rel_instr", if0.instruction, 32'd3);
    check("rel_en",    {31'd0, if0.imem_en}, 32'd0);

    tick(); #1;
    check("skid_instr", if0.instruction, 32'd4);
    check("skid_pc4",   if0.pc_plus4, 32'd20);
    check("skid_en",    {31'd0, if0.imem_en}, 32'd1);
    check("skid_addr",  if0.imem_addr, 32'd20);

    tick(); #1;
    check("bub_valid", {31'd0, if0.valid_out}, 32'd0);

    tick(); #1;
    check("res_instr5", if0.instruction, 32'd5);
    check("res_pc4_5",  if0.pc_plus4, 32'd24);

    // jump
    tick();
    jump         = 1'b1;
    redirect_pc4 = 32'h1000_0010;
    jump_addr    = 26'h000_0040;
    #1;
    check("res_instr6", if0.instruction, 32'd6);
    check("res_pc4_6",  if0.pc_plus4, 32'd28);

    tick();
    jump = 1'b0;
    #1;
    check("j_addr",  if0.imem_addr, 32'h1000_0100);
    check("j_en",    {31'd0, if0.imem_en}, 32'd1);
    check("j_valid", {31'd0, if0.valid_out}, 32'd0);

    tick(); #1;
    check("j_discard", {31'd0, if0.valid_out}, 32'd0);

    tick(); #1;
    check("j_tvalid", {31'd0, if0.valid_out}, 32'd1);
    check("j_tinstr", if0.instruction, 32'h0400_0040);
    check("j_tpc4",   if0.pc_plus4, 32'h1000_0104);

    // branch
    branch_taken = 1'b1;
    redirect_pc4 = 32'h0000_0020;
    branch_imm   = 16'hFFFE;
    tick();
    branch_taken = 1'b0;
    #1;
    check("b_addr",  if0.imem_addr, 32'h0000_0018);
    check("b_valid", {31'd0, if0.valid_out}, 32'd0);

    tick();
    tick(); #1;
    check("b_instr", if0.instruction, 32'd6);
    check("b_pc4",   if0.pc_plus4, 32'h0000_001C);

    // branch and jump together: jump wins
    branch_taken = 1'b1;
    jump         = 1'b1;
    jump_addr    = 26'h000_0000;
    tick();
    branch_taken = 1'b0;
    jump         = 1'b0;
    #1;
    check("bj_addr",  if0.imem_addr, 32'h0000_0000);
    check("bj_valid", {31'd0, if0.valid_out}, 32'd0);
`ifdef IFETCH_PERF_EN
    check("perf_redir", rc0, 32'd3);
`endif

    tick();
    tick();
    if0.ready_in = 1'b0;
    #1;
    check("bj_instr", if0.instruction, 32'd0);
    check("bj_pc4",   if0.pc_plus4, 32'd4);
    check("bj_st_en", {31'd0, if0.imem_en}, 32'd0);

    tick(); #1;
    check("sf_valid", {31'd0, if0.valid_out}, 32'd1);
    check("sf_en",    {31'd0, if0.imem_en}, 32'd0);
`ifdef IFETCH_PERF_EN
    check("perf_stall", sc0, 32'd6);
`endif

    // reset while stalled with the skid full
    reset = 1'b1;
    tick(); #1;
    check("mr_valid", {31'd0, if0.valid_out}, 32'd0);
    check("mr_instr", if0.instruction, 32'd0);
    check("mr_addr",  if0.imem_addr, 32'd0);
    check("mr_en",    {31'd0, if0.imem_en}, 32'd0);
`ifdef IFETCH_PERF_EN
    check("mr_stall", sc0, 32'd0);
    check("mr_redir", rc0, 32'd0);
`endif
    reset        = 1'b0;
    if0.ready_in = 1'b1;
    #1;
    check("mr_en_rel", {31'd0, if0.imem_en}, 32'd1);

    tick();
    tick(); #1;
    check("mr_instr0", if0.instruction, 32'd0);
    check("mr_pc4_0",  if0.pc_plus4, 32'd4);
    check("mr_valid0", {31'd0, if0.valid_out}, 32'd1);

    tick(); #1;
    check("mr_instr1", if0.instruction, 32'd1);
    check("mr_pc4_1",  if0.pc_plus4, 32'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
